// File: rtl/poly_result_collector.sv
// Result FIFO behind the series-evaluator datapath: buffers unstallable result pulses,
// presents them downstream via valid/ready, and tracks drops and overflow status.
// Optional macro RESULT_SAT_EN: saturate results that arrive with the overflow flag set.
module poly_result_collector #(
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1,
    parameter int DATA_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_result,
    input  logic                     in_ov,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_result,
    output logic                     out_ov,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [7:0]               drop_cnt,
    output logic                     ov_sticky,
    input  logic                     clr_status
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int AF_TH = DEPTH - AF_MARGIN;

    // Value actually stored for a pushed result; wrapped results may be clamped.
    function automatic logic [DATA_W-1:0] store_value(input logic [DATA_W-1:0] res, input logic ov);
`ifdef RESULT_SAT_EN
        logic [DATA_W-1:0] v;
        if (ov && res[DATA_W-1]) begin
            v = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (ov) begin
            v = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            v = res;
        end
        return v;
`else
        return (ov == 1'b1) ? res : res;
`endif
    endfunction

    logic [DATA_W:0]   mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              empty_r, full_r, af_r, out_valid_r, ov_sticky_r;
    logic [DATA_W-1:0] head_result_r;
    logic              head_ov_r;
    logic [7:0]        drop_cnt_r;

    logic              push_s, pop_s, drop_s;
    logic [DATA_W:0]   wdata_s;
    logic [AW-1:0]     rd_next_s;
    logic [CW-1:0]     count_next_s;
    logic [DATA_W:0]   head_next_s;
    logic              af_next_s;
    logic [7:0]        drop_next_s;
    logic              sticky_next_s;

    // Handshake decode and next-state computation for flags, head and status.
    always_comb begin
        pop_s         = out_valid_r & out_ready;
        push_s        = in_valid & (~full_r | pop_s);
        drop_s        = in_valid & full_r & ~pop_s;
        wdata_s       = {in_ov, store_value(in_result, in_ov)};
        rd_next_s     = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        count_next_s  = count_r;
        head_next_s   = '0;
        af_next_s     = 1'b0;
        drop_next_s   = drop_cnt_r;
        sticky_next_s = ov_sticky_r;

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase

        // The registered head must already reflect an entry written on this edge.
        if (count_next_s == CW'(0)) begin
            head_next_s = '0;
        end else if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = wdata_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end

        if (AF_TH <= 0) begin
            af_next_s = 1'b1;
        end else begin
            af_next_s = (count_next_s >= CW'(AF_TH));
        end

        if (clr_status) begin
            drop_next_s   = drop_s ? 8'd1 : 8'd0;
            sticky_next_s = push_s & in_ov;
        end else begin
            drop_next_s   = (drop_s && (drop_cnt_r != 8'd255)) ? (drop_cnt_r + 8'd1) : drop_cnt_r;
            sticky_next_s = ov_sticky_r | (push_s & in_ov);
        end
    end

    // Entry storage; contents are don't-care until pushed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            mem_r[wr_ptr_r] <= wdata_s;
        end
    end

    // Pointers, occupancy flags, registered head and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            empty_r       <= 1'b1;
            full_r        <= 1'b0;
            af_r          <= (AF_TH <= 0);
            out_valid_r   <= 1'b0;
            head_result_r <= '0;
            head_ov_r     <= 1'b0;
            drop_cnt_r    <= 8'd0;
            ov_sticky_r   <= 1'b0;
        end else begin
            wr_ptr_r      <= push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_ptr_r      <= rd_next_s;
            count_r       <= count_next_s;
            empty_r       <= (count_next_s == CW'(0));
            full_r        <= (count_next_s == CW'(DEPTH));
            af_r          <= af_next_s;
            out_valid_r   <= (count_next_s != CW'(0));
            head_result_r <= head_next_s[DATA_W-1:0];
            head_ov_r     <= head_next_s[DATA_W];
            drop_cnt_r    <= drop_next_s;
            ov_sticky_r   <= sticky_next_s;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_result  = head_result_r;
    assign out_ov      = head_ov_r;
    assign count       = count_r;
    assign empty       = empty_r;
    assign full        = full_r;
    assign almost_full = af_r;
    assign drop_cnt    = drop_cnt_r;
    assign ov_sticky   = ov_sticky_r;
endmodule

// File: doc/poly_result_collector.md
Name: poly_result_collector

Overview:
- Receiving end of the series-evaluator datapath's result interface.
- The datapath pulses valid for one cycle with result/ov_flag and cannot be stalled, so this block buffers every pulse in a FIFO.
- It presents entries downstream through a valid/ready handshake.
- It returns almost_full to the controller so the controller withholds load, and keeps drop and overflow status.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >=2)
AF_MARGIN, 1, almost_full asserts when count >= DEPTH-AF_MARGIN
DATA_W, 32, result width (signed fixed-point, as produced by the datapath adders)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset
in_valid  input  1  one-cycle result strobe from datapath valid
in_result  input  DATA_W  datapath result, sampled when in_valid=1
in_ov  input  1  datapath ov_flag, sampled with in_result
out_valid  output  1  head entry available
out_ready  input  1  downstream accepts head
out_result  output  DATA_W  head result
out_ov  output  1  head overflow flag
count  output  $clog2(DEPTH)+1  entries held
empty  output  1  count==0
full  output  1  count==DEPTH
almost_full  output  1  count>=DEPTH-AF_MARGIN; controller gates load with it
drop_cnt  output  8  results lost to a full FIFO, saturates at 255
ov_sticky  output  1  set when any accepted entry carried in_ov=1
clr_status  input  1  clears drop_cnt and ov_sticky

Behaviour:
- Reset (rst=0 at a clk edge): pointers=0; count=0; empty=1; full=0; almost_full=0 (unless DEPTH-AF_MARGIN<=0); out_valid=0; out_result=0; out_ov=0; drop_cnt=0; ov_sticky=0.
- Reset mid-operation discards all stored entries and any in_valid pulse in that cycle.
- Push: in_valid=1 and (not full, or a pop occurs in the same cycle).
  - Writes {in_ov,in_result} at the write pointer; pointer wraps modulo DEPTH.
- Pop: out_valid=1 and out_ready=1. Read pointer advances and wraps modulo DEPTH.
- Output timing:
  - Head is first-word-fall-through from storage; out_* are driven from the read-pointer entry.
  - A pushed entry is visible on out_valid/out_result the cycle after the push edge; no same-cycle bypass.
  - Push-to-out_valid latency is 1 cycle when empty.
- Simultaneous push and pop:
  - count unchanged; both succeed, including when full and when count==1.
  - When count==1, the new entry appears at the head next cycle.
- Drop: in_valid=1, full=1, and no pop.
  - Entry discarded; storage and pointers unchanged.
  - drop_cnt increments, holding at 255.
- Flags:
  - count, empty, full and almost_full are registered and consistent with the post-edge state.
  - out_valid == !empty.
- out_valid/out_result/out_ov stay stable while out_valid=1 and out_ready=0.
- ov_sticky: set on an accepted push with in_ov=1; dropped entries never set it.
- clr_status=1:
  - Zeroes drop_cnt and ov_sticky next edge.
  - A same-cycle set event wins: ov_sticky=1, and drop_cnt=1 if a drop coincides.
- No state machine beyond the FIFO. Occupancy comes from a count register updated +1 (push only), −1 (pop only), or 0.

Optional Feature:
RESULT_SAT_EN:
- Defined: on push with in_ov=1, the stored result is saturated instead of the wrapped value.
  - If in_result[DATA_W-1]=1 (wrapped from positive), store max positive (0x7FFFFFFF for DATA_W=32).
  - Otherwise store most negative (0x80000000).
  - out_ov is still 1.
- Undefined: in_result is stored unmodified.

Test Plan:
- Reset, then a single in_valid with in_result=0x00012345, in_ov=0 → next cycle out_valid=1, out_result=0x00012345, count=1; out_ready=1 that cycle → empty=1 on the following cycle.
- DEPTH=4, out_ready=0, 4 pushes of 1..4 → full=1, almost_full asserted at count=3; drain with out_ready=1 → outputs 1,2,3,4 in order, empty=1 after the 4th.
- Full FIFO, out_ready=0, 3 more in_valid pulses → drop_cnt=3 and contents still 1..4; clr_status pulse → drop_cnt=0.
- Full FIFO with in_valid and out_ready both high for 2 cycles → count stays 4, no drop; stream order preserved (1,2 popped, 5,6 appended).
- in_valid with in_result=0x80000010, in_ov=1 → ov_sticky=1, out_ov=1; out_result=0x7FFFFFFF with RESULT_SAT_EN, 0x80000010 without.
- Hold 3 entries, assert rst=0 for one edge with simultaneous in_valid → all outputs at reset values; no entry is retained.
